// File: rtl/ref_window_buffer.sv
// Reference search-window buffer: a ring of single-port banks written one column
// block at a time, emitting one WIN_PIX-wide window row per accepted word.
module ref_window_buffer #(
    parameter int PIX_W           = 8,
    parameter int PIX_PER_WORD    = 8,
    parameter int NUM_BANKS       = 4,
    parameter int ROWS            = 23,
    parameter int WIN_PIX         = 23,
    parameter int BLOCKS_PER_LINE = 482
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PIX_W*PIX_PER_WORD-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [PIX_W*WIN_PIX-1:0]     out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(ROWS)-1:0]      out_row,
    output logic                         line_done
);
    localparam int WORD_W  = PIX_W * PIX_PER_WORD;
    localparam int WIN_W   = PIX_W * WIN_PIX;
    localparam int CAT_W   = (NUM_BANKS - 1) * WORD_W;
    localparam int ROW_W   = $clog2(ROWS);
    localparam int BANK_W  = $clog2(NUM_BANKS);
    localparam int BLK_W   = $clog2(BLOCKS_PER_LINE + 1);
    localparam int PRIME_W = $clog2(NUM_BANKS);

    typedef enum logic [1:0] {ST_PRIME, ST_RUN, ST_FLUSH} state_t;

    state_t               state_r, state_s;
    logic [BANK_W-1:0]    wr_bank_r, wr_bank_s;
    logic [ROW_W-1:0]     row_r, row_s;
    logic [BLK_W-1:0]     blk_cnt_r, blk_cnt_s;
    logic [PRIME_W-1:0]   primed_r, primed_s;
    logic                 line_end_s;
    logic                 in_ready_s, accept_s;
    logic [WORD_W-1:0]    rd_word_s [NUM_BANKS];
    logic [CAT_W-1:0]     cat_s;
    logic                 out_valid_r, line_done_r;
    logic [WIN_W-1:0]     out_data_r;
    logic [ROW_W-1:0]     out_row_r;

    assign in_ready_s = !rst && (state_r != ST_FLUSH) && (!out_valid_r || out_ready);
    assign accept_s   = in_valid && in_ready_s;

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            logic [WORD_W-1:0] mem_r [ROWS];
            // Bank storage: written only while this bank is the ring's write target
            always_ff @(posedge clk) begin
                if (accept_s && (wr_bank_r == BANK_W'(b))) begin
                    mem_r[row_r] <= in_data;
                end
            end
            assign rd_word_s[b] = mem_r[row_r];
        end
    endgenerate

    // Window assembly: banks after the write bank, oldest first in the MSBs
    always_comb begin
        logic [BANK_W-1:0] idx;
        cat_s = '0;
        idx   = '0;
        for (int k = 1; k < NUM_BANKS; k++) begin
            idx = BANK_W'((int'(wr_bank_r) + k) % NUM_BANKS);
            cat_s[CAT_W - k*WORD_W +: WORD_W] = rd_word_s[idx];
        end
    end

    // Next-state logic: row/bank/block counters and PRIME/RUN/FLUSH sequencing
    always_comb begin
        state_s    = state_r;
        wr_bank_s  = wr_bank_r;
        row_s      = row_r;
        blk_cnt_s  = blk_cnt_r;
        primed_s   = primed_r;
        line_end_s = 1'b0;
        case (state_r)
            ST_PRIME, ST_RUN: begin
                if (accept_s) begin
                    if (row_r == ROW_W'(ROWS - 1)) begin
                        row_s     = '0;
                        wr_bank_s = (wr_bank_r == BANK_W'(NUM_BANKS - 1)) ? '0 : wr_bank_r + BANK_W'(1);
                        blk_cnt_s = blk_cnt_r + BLK_W'(1);
                        if (primed_r != PRIME_W'(NUM_BANKS - 1)) begin
                            primed_s = primed_r + PRIME_W'(1);
                        end else begin
                            primed_s = primed_r;
                        end
                        // Line end wins over the prime-complete transition
                        if (blk_cnt_r == BLK_W'(BLOCKS_PER_LINE - 1)) begin
                            state_s    = ST_FLUSH;
                            line_end_s = 1'b1;
                        end else if ((state_r == ST_PRIME) && (primed_r == PRIME_W'(NUM_BANKS - 2))) begin
                            state_s = ST_RUN;
                        end else begin
                            state_s = state_r;
                        end
                    end else begin
                        row_s = row_r + ROW_W'(1);
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_FLUSH: begin
                state_s   = ST_PRIME;
                wr_bank_s = '0;
                row_s     = '0;
                blk_cnt_s = '0;
                primed_s  = '0;
            end
            default: begin
                state_s   = ST_PRIME;
                wr_bank_s = '0;
                row_s     = '0;
                blk_cnt_s = '0;
                primed_s  = '0;
            end
        endcase
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_PRIME;
            wr_bank_r <= '0;
            row_r     <= '0;
            blk_cnt_r <= '0;
            primed_r  <= '0;
        end else begin
            state_r   <= state_s;
            wr_bank_r <= wr_bank_s;
            row_r     <= row_s;
            blk_cnt_r <= blk_cnt_s;
            primed_r  <= primed_s;
        end
    end

    // Output register: capture a window on RUN accepts, hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_row_r   <= '0;
            line_done_r <= 1'b0;
        end else begin
            line_done_r <= line_end_s;
            if (accept_s && (state_r == ST_RUN)) begin
                out_valid_r <= 1'b1;
                out_data_r  <= WIN_W'(cat_s >> (CAT_W - WIN_W));
                out_row_r   <= row_r;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_row   = out_row_r;
    assign line_done = line_done_r;

endmodule

// File: tb/tb_ref_window_buffer.sv
// Randomised bench for ref_window_buffer: a line-level model predicts every window row,
// handshake and line_done pulse from the previous NUM_BANKS-1 blocks of the current line.
module tb_ref_window_buffer;
    localparam int PW     = 8;
    localparam int PPW    = 4;
    localparam int NB     = 5;
    localparam int RW     = 16;
    localparam int WP     = 13;
    localparam int BPL    = 6;
    localparam int WORD_W = PW * PPW;
    localparam int WIN_W  = PW * WP;
    localparam int CAT_W  = (NB - 1) * WORD_W;

    logic                    clk = 1'b0;
    logic                    rst, in_valid, in_ready, out_valid, out_ready, line_done;
    logic [WORD_W-1:0]       in_data;
    logic [WIN_W-1:0]        out_data;
    logic [$clog2(RW)-1:0]   out_row;

    always #5 clk = ~clk;

    ref_window_buffer #(
        .PIX_W(PW), .PIX_PER_WORD(PPW), .NUM_BANKS(NB), .ROWS(RW),
        .WIN_PIX(WP), .BLOCKS_PER_LINE(BPL)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .line_done(line_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: words of the current line, indexed by block and row
    logic [WORD_W-1:0] lw [BPL][RW];
    logic [WIN_W-1:0]  exp_data_q [$];
    int                exp_row_q  [$];
    int  m_blk, m_row, acc_since, first_lat, lines_done;
    bit  m_ov, m_ld, m_flush, did_rst, rst_now, exp_ready, take, acc, next_ov;

    function automatic logic [WIN_W-1:0] window(input int blk, input int row);
        logic [CAT_W-1:0] full;
        full = '0;
        for (int k = NB - 1; k >= 1; k--) begin
            full = (full << WORD_W) | CAT_W'(lw[blk - k][row]);
        end
        return WIN_W'(full >> (CAT_W - WIN_W));
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        m_blk = 0; m_row = 0; m_ov = 1'b0; m_ld = 1'b0; m_flush = 1'b0;
        acc_since = 0; first_lat = -1; lines_done = 0; did_rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_row", out_row, 0);
        check("rst_line_done", line_done, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            check("out_valid", out_valid, m_ov);
            check("line_done", line_done, m_ld);
            if (first_lat < 0 && out_valid) begin
                first_lat = acc_since;
                check("prime_latency", first_lat, (NB - 1) * RW + 1);
            end

            rst_now = !did_rst && lines_done >= 1 && m_blk == 4 && m_row == 10 && m_ov;
            if (cyc < 80)        begin in_valid = 1'b1; out_ready = 1'b1; end
            else if (cyc < 85)   begin in_valid = 1'b1; out_ready = 1'b0; end
            else if (cyc < 200)  begin in_valid = 1'b1; out_ready = 1'b1; end
            else if (cyc < 3980) begin
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            in_data = $urandom;
            rst = rst_now;
            #1;
            exp_ready = !rst_now && !m_flush && (!m_ov || out_ready);
            check("in_ready", in_ready, exp_ready);

            if (rst_now) begin
                did_rst = 1'b1;
                m_blk = 0; m_row = 0; m_ov = 1'b0; m_ld = 1'b0; m_flush = 1'b0;
                exp_data_q.delete(); exp_row_q.delete();
                acc_since = 0; first_lat = -1;
            end else begin
                take = m_ov && out_ready;
                if (take) begin
                    if (exp_data_q.size() == 0) begin
                        check("scoreboard_underflow", 1, 0);
                    end else begin
                        check("out_data", out_data, exp_data_q.pop_front());
                        check("out_row", out_row, exp_row_q.pop_front());
                    end
                end
                acc     = in_valid && exp_ready;
                next_ov = m_ov && !out_ready;
                m_ld    = 1'b0;
                m_flush = 1'b0;
                if (acc) begin
                    lw[m_blk][m_row] = in_data;
                    acc_since++;
                    if (m_blk >= NB - 1) begin
                        exp_data_q.push_back(window(m_blk, m_row));
                        exp_row_q.push_back(m_row);
                        next_ov = 1'b1;
                    end
                    m_row++;
                    if (m_row == RW) begin
                        m_row = 0;
                        m_blk++;
                        if (m_blk == BPL) begin
                            m_blk = 0; m_ld = 1'b1; m_flush = 1'b1;
                            lines_done++;
                        end
                    end
                end
                m_ov = next_ov;
            end
        end
        @(negedge clk);
        check("final_out_valid", out_valid, 0);
        check("scoreboard_empty", exp_data_q.size(), 0);
        check("reset_exercised", did_rst, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
